control_unit: RTL and testbench

Micro-sequenced control FSM that drives the register unit: it fetches each instruction through AR/DR, loads IR, decodes the 6-bit opcode, and issues the per-cycle C-bus write enables, B-bus mux select, increment strobes, ALU op and RAM strobes. It sits directly upstream of the register unit and ALU, and consumes the IR opcode and the ALU zero flag.

---
 rtl/cpu_pkg.sv | 85 ++++++++
 rtl/control_decoder.sv | 103 ++++++++++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control states, opcodes, B-bus selects, C-bus bit indices and ALU ops.
// Used by the control unit, the register unit and the ALU.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_F3   = 4'd3,
        ST_F4   = 4'd4,
        ST_DEC  = 4'd5,
        ST_EX1  = 4'd6,
        ST_EX2  = 4'd7,
        ST_EX3  = 4'd8,
        ST_EX4  = 4'd9,
        ST_HALT = 4'd10
    } state_t;

    localparam int OPCODE_W = 6;
    localparam int CBUS_W   = 10;
    localparam int SEL_W    = 4;
    localparam int ALU_W    = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LDAC  = 6'h01;
    localparam logic [OPCODE_W-1:0] OP_STAC  = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_MVR1  = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_INCRA = 6'h06;
    localparam logic [OPCODE_W-1:0] OP_INCAC = 6'h07;
    localparam logic [OPCODE_W-1:0] OP_JMPZ  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 6'h3F;

    localparam logic [SEL_W-1:0] SEL_DR = 4'd0;
    localparam logic [SEL_W-1:0] SEL_R1 = 4'd1;
    localparam logic [SEL_W-1:0] SEL_R2 = 4'd2;
    localparam logic [SEL_W-1:0] SEL_R3 = 4'd3;
    localparam logic [SEL_W-1:0] SEL_RA = 4'd4;
    localparam logic [SEL_W-1:0] SEL_RB = 4'd5;
    localparam logic [SEL_W-1:0] SEL_RC = 4'd6;
    localparam logic [SEL_W-1:0] SEL_AC = 4'd7;
    localparam logic [SEL_W-1:0] SEL_PC = 4'd8;

    localparam int C_PC = 9;
    localparam int C_RA = 8;
    localparam int C_RB = 7;
    localparam int C_RC = 6;
    localparam int C_R1 = 5;
    localparam int C_R2 = 4;
    localparam int C_R3 = 3;
    localparam int C_DR = 2;
    localparam int C_AR = 1;
    localparam int C_AC = 0;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

    typedef struct packed {
        logic              ldir;
        logic              pc_inc;
        logic              ac_inc;
        logic              ra_inc;
        logic              rb_inc;
        logic              rc_inc;
        logic [CBUS_W-1:0] c_bus;
        logic [SEL_W-1:0]  select;
        logic [ALU_W-1:0]  alu_op;
        logic              dr_read;
        logic              mem_read;
        logic              mem_write;
        logic              halted;
    } ctrl_t;

    // One-hot C-bus write enable for a register index.
    function automatic logic [CBUS_W-1:0] cbit(input int idx);
        return CBUS_W'(1) << idx;
    endfunction

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        return (op <= OP_JMPZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Pure combinational map from (state, latched opcode, latched z) to the control vector.
// Latency: zero (combinational). Backpressure: none, outputs follow state.
// Every state not listed below drives an all-zero vector.
module control_decoder
    import cpu_pkg::*;
(
    input  state_t                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  z,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_F1: begin
                ctrl.select = SEL_PC;
                ctrl.c_bus  = cbit(C_AR);
            end
            ST_F2: ctrl.mem_read = 1'b1;
            ST_F3: begin
                ctrl.dr_read = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            ST_F4: ctrl.ldir = 1'b1;
            ST_EX1: begin
                case (opcode)
                    OP_LDAC, OP_STAC: begin
                        ctrl.select = SEL_RA;
                        ctrl.c_bus  = cbit(C_AR);
                    end
                    OP_MVR1: begin
                        ctrl.select = SEL_AC;
                        ctrl.alu_op = ALU_PASS;
                        ctrl.c_bus  = cbit(C_R1);
                    end
                    OP_ADD: begin
                        ctrl.select = SEL_R1;
                        ctrl.alu_op = ALU_ADD;
                        ctrl.c_bus  = cbit(C_AC);
                    end
                    OP_SUB: begin
                        ctrl.select = SEL_R1;
                        ctrl.alu_op = ALU_SUB;
                        ctrl.c_bus  = cbit(C_AC);
                    end
                    OP_INCRA: ctrl.ra_inc = 1'b1;
                    OP_INCAC: ctrl.ac_inc = 1'b1;
                    OP_JMPZ: begin
                        // Taken: fetch the target word. Not taken: step over it.
                        if (z) begin
                            ctrl.select = SEL_PC;
                            ctrl.c_bus  = cbit(C_AR);
                        end else begin
                            ctrl.pc_inc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EX2: begin
                case (opcode)
                    OP_LDAC: ctrl.mem_read = 1'b1;
                    OP_JMPZ: ctrl.mem_read = z;
                    OP_STAC: begin
                        ctrl.select = SEL_AC;
                        ctrl.alu_op = ALU_PASS;
                        ctrl.c_bus  = cbit(C_DR);
                    end
                    default: ;
                endcase
            end
            ST_EX3: begin
                case (opcode)
                    OP_LDAC: ctrl.dr_read   = 1'b1;
                    OP_JMPZ: ctrl.dr_read   = z;
                    OP_STAC: ctrl.mem_write = 1'b1;
                    default: ;
                endcase
            end
            ST_EX4: begin
                case (opcode)
                    OP_LDAC: begin
                        ctrl.select = SEL_DR;
                        ctrl.alu_op = ALU_PASS;
                        ctrl.c_bus  = cbit(C_AC);
                    end
                    OP_JMPZ: begin
                        if (z) begin
                            ctrl.select = SEL_DR;
                            ctrl.alu_op = ALU_PASS;
                            ctrl.c_bus  = cbit(C_PC);
                        end
                    end
                    default: ;
                endcase
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Micro-sequenced fetch/decode/execute controller for the register unit, ALU and RAM.
// Latency: Moore outputs, one state per cycle; 5-9 cycles per instruction from F1.
// Backpressure: none; start is a one-shot that only matters in IDLE.
module control_unit
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 z_flag,
    output logic                 LDIR,
    output logic                 PC_INC,
    output logic                 AC_INC,
    output logic                 RA_INC,
    output logic                 RB_INC,
    output logic                 RC_INC,
    output logic [CBUS_W-1:0]    C_bus_ctrl_sig,
    output logic [SEL_W-1:0]     select,
    output logic [ALU_W-1:0]     alu_op,
    output logic                 dr_read,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 halted,
    output logic                 illegal
);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                z_q;
    logic                illegal_q;
    logic                long_op;
    logic                four_ex;
    ctrl_t               ctrl;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode and zero flag are frozen in DEC so execute states ignore later input changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == ST_DEC) begin
            op_q <= opcode;
            z_q  <= z_flag;
            if (!op_is_legal(opcode)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign long_op = (op_q == OP_LDAC) || (op_q == OP_STAC) || ((op_q == OP_JMPZ) && z_q);
    assign four_ex = (op_q == OP_LDAC) || ((op_q == OP_JMPZ) && z_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2:   state_d = ST_F3;
            ST_F3:   state_d = ST_F4;
            ST_F4:   state_d = ST_DEC;
            ST_DEC: begin
                if (opcode == OP_NOP) begin
                    state_d = ST_F1;
                end else if ((opcode == OP_HALT) || !op_is_legal(opcode)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EX1;
                end
            end
            ST_EX1:  state_d = long_op ? ST_EX2 : ST_F1;
            ST_EX2:  state_d = long_op ? ST_EX3 : ST_F1;
            ST_EX3:  state_d = four_ex ? ST_EX4 : ST_F1;
            ST_EX4:  state_d = ST_F1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: driven only by registered state, so reset clears it without a clock.
    control_decoder u_decoder (
        .state  (state_q),
        .opcode (op_q),
        .z      (z_q),
        .ctrl   (ctrl)
    );

    assign LDIR           = ctrl.ldir;
    assign PC_INC         = ctrl.pc_inc;
    assign AC_INC         = ctrl.ac_inc;
    assign RA_INC         = ctrl.ra_inc;
    assign RB_INC         = ctrl.rb_inc;
    assign RC_INC         = ctrl.rc_inc;
    assign C_bus_ctrl_sig = ctrl.c_bus;
    assign select         = ctrl.select;
    assign alu_op         = ctrl.alu_op;
    assign dr_read        = ctrl.dr_read;
    assign mem_read       = ctrl.mem_read;
    assign mem_write      = ctrl.mem_write;
    assign halted         = ctrl.halted;
    assign illegal        = illegal_q;

`ifndef SYNTHESIS
    a_cbus_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(C_bus_ctrl_sig));
    a_inc_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({PC_INC, AC_INC, RA_INC, RB_INC, RC_INC}));
    a_mem_excl: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: per-instruction micro-op scripts are expanded into
// expected per-cycle output vectors and compared cycle by cycle on the falling edge.
module tb_control_unit;

    typedef struct packed {
        logic       ldir;
        logic       pc_inc;
        logic       ac_inc;
        logic       ra_inc;
        logic       rb_inc;
        logic       rc_inc;
        logic [9:0] c_bus;
        logic [3:0] sel;
        logic [2:0] alu;
        logic       dr_read;
        logic       mem_read;
        logic       mem_write;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       z_flag;
    logic       LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
    logic [9:0] C_bus_ctrl_sig;
    logic [3:0] select;
    logic [2:0] alu_op;
    logic       dr_read, mem_read, mem_write, halted, illegal;

    obs_t cur;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    control_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .opcode         (opcode),
        .z_flag         (z_flag),
        .LDIR           (LDIR),
        .PC_INC         (PC_INC),
        .AC_INC         (AC_INC),
        .RA_INC         (RA_INC),
        .RB_INC         (RB_INC),
        .RC_INC         (RC_INC),
        .C_bus_ctrl_sig (C_bus_ctrl_sig),
        .select         (select),
        .alu_op         (alu_op),
        .dr_read        (dr_read),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .halted         (halted),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    assign cur = {LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC, C_bus_ctrl_sig,
                  select, alu_op, dr_read, mem_read, mem_write, halted, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Register transfer: B-bus source, ALU op, destination register bit on the C bus.
    function automatic obs_t xfer(input int sel, input int alu, input int dst);
        obs_t o = '0;
        o.sel   = 4'(sel);
        o.alu   = 3'(alu);
        o.c_bus = 10'(1) << dst;
        return o;
    endfunction

    function automatic obs_t strobe(input string s);
        obs_t o = '0;
        case (s)
            "ldir":   o.ldir = 1'b1;
            "pc_inc": o.pc_inc = 1'b1;
            "ac_inc": o.ac_inc = 1'b1;
            "ra_inc": o.ra_inc = 1'b1;
            "mr":     o.mem_read = 1'b1;
            "mw":     o.mem_write = 1'b1;
            "drr":    o.dr_read = 1'b1;
            "fetch3": begin o.dr_read = 1'b1; o.pc_inc = 1'b1; end
            default:  ;
        endcase
        return o;
    endfunction

    // Expected per-cycle outputs of one instruction, starting at F1.
    task automatic build(input logic [5:0] op, input logic z);
        exp_q.delete();
        exp_q.push_back(xfer(8, 0, 1));     // AR <- PC
        exp_q.push_back(strobe("mr"));
        exp_q.push_back(strobe("fetch3"));
        exp_q.push_back(strobe("ldir"));
        exp_q.push_back(strobe("none"));    // decode
        case (op)
            6'h01: begin
                exp_q.push_back(xfer(4, 0, 1));
                exp_q.push_back(strobe("mr"));
                exp_q.push_back(strobe("drr"));
                exp_q.push_back(xfer(0, 0, 0));
            end
            6'h02: begin
                exp_q.push_back(xfer(4, 0, 1));
                exp_q.push_back(xfer(7, 0, 2));
                exp_q.push_back(strobe("mw"));
            end
            6'h03: exp_q.push_back(xfer(7, 0, 5));
            6'h04: exp_q.push_back(xfer(1, 1, 0));
            6'h05: exp_q.push_back(xfer(1, 2, 0));
            6'h06: exp_q.push_back(strobe("ra_inc"));
            6'h07: exp_q.push_back(strobe("ac_inc"));
            6'h08: begin
                if (z) begin
                    exp_q.push_back(xfer(8, 0, 1));
                    exp_q.push_back(strobe("mr"));
                    exp_q.push_back(strobe("drr"));
                    exp_q.push_back(xfer(0, 0, 9));
                end else begin
                    exp_q.push_back(strobe("pc_inc"));
                end
            end
            default: ;
        endcase
    endtask

    // Entered at a falling edge with the DUT in F1; checks up to 'limit' cycles.
    task automatic run_instr(input logic [5:0] op, input logic z, input int limit);
        int n;
        build(op, z);
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                opcode = op;
                z_flag = z;
            end else if (i >= 5) begin
                opcode = 6'($urandom_range(63));
                z_flag = 1'($urandom_range(1));
            end
            start = 1'($urandom_range(1));
            check($sformatf("op%02h_z%0d_c%0d", op, z, i), 32'(cur), 32'(exp_q[i]));
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(cur), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        obs_t halt_v;
        logic [5:0] op;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 6'h00;
        z_flag = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(cur), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        idle_cycles("idle_no_start", 2);

        go();
        run_instr(6'h00, 1'b0, 100);
        run_instr(6'h04, 1'b1, 100);
        run_instr(6'h08, 1'b1, 100);
        run_instr(6'h08, 1'b0, 100);
        run_instr(6'h02, 1'b0, 100);
        run_instr(6'h01, 1'b1, 100);
        run_instr(6'h03, 1'b0, 100);
        run_instr(6'h05, 1'b1, 100);
        run_instr(6'h06, 1'b0, 100);
        run_instr(6'h07, 1'b1, 100);
        for (int k = 0; k < 60; k++) begin
            op = 6'($urandom_range(8));
            run_instr(op, 1'($urandom_range(1)), 100);
        end

        // Reset in the middle of LDAC EX2: the AC load in EX4 must never happen.
        run_instr(6'h01, 1'b0, 6);
        check("ldac_ex2", 32'(cur), 32'(exp_q[6]));
        #1 reset = 1'b1;
        #1 check("async_reset_ldac", 32'(cur), 32'd0);
        @(negedge clk);
        idle_cycles("held_reset", 2);
        reset = 1'b0;
        idle_cycles("after_reset", 3);
        go();
        run_instr(6'h04, 1'b0, 100);

        // Undefined opcode: sticky illegal plus halt, start ignored.
        run_instr(6'h15, 1'b0, 100);
        halt_v = '0;
        halt_v.halted  = 1'b1;
        halt_v.illegal = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start  = 1'($urandom_range(1));
            opcode = 6'($urandom_range(63));
            check($sformatf("illegal_halt_%0d", i), 32'(cur), 32'(halt_v));
            @(negedge clk);
        end
        start = 1'b0;
        #1 reset = 1'b1;
        #1 check("reset_clears_illegal", 32'(cur), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles("idle_after_illegal", 2);

        // HALT opcode: halted without illegal.
        go();
        run_instr(6'h3F, 1'b1, 100);
        halt_v.illegal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            check($sformatf("halt_%0d", i), 32'(cur), 32'(halt_v));
            @(negedge clk);
        end
        start = 1'b0;
        #1 reset = 1'b1;
        #1 check("reset_clears_halt", 32'(cur), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles("final_idle", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
